// File: rtl/pipeline_elastic.sv
// -----------------------------------------------------------------------------
// pipeline_elastic
//
// Purpose:
//   Multi-stage data pipeline with valid/ready flow control. Each stage is a
//   two-entry skid buffer (main + skid register). Because the upstream ready of
//   a stage is a flop, no combinational ready path crosses stage boundaries.
//   Data flows downstream and backpressure ripples upstream one stage per
//   clock. Every stage stores up to two words, so the pipeline holds up to
//   2*NOF_STAGES words in total.
//
// Parameters:
//   WIDTH       data width in bits (>= 1)
//   NOF_STAGES  number of skid-buffer stages (>= 1)
//
// Ports:
//   clk_i      clock; all state changes on the rising edge
//   rst_i      asynchronous, active-high reset
//   s_valid_i  upstream word valid
//   s_data_i   upstream data
//   s_ready_o  block accepts a word (flop output)
//   m_valid_o  downstream word valid (flop output)
//   m_data_o   downstream data (flop output)
//   m_ready_i  downstream accepts the word
// -----------------------------------------------------------------------------
module pipeline_elastic #(
    parameter int WIDTH      = 8,
    parameter int NOF_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i
);

    // State encoding is chosen so that bit 0 is the main-valid flag and bit 1
    // the skid-valid flag; both flags are therefore plain flop bits.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b11
    } stage_state_e;

    // Inter-stage wiring: what each stage presents downstream and upstream.
    logic             stage_valid [NOF_STAGES];
    logic [WIDTH-1:0] stage_data  [NOF_STAGES];
    logic             stage_ready [NOF_STAGES];

    if (NOF_STAGES < 1) begin : g_bad_nof_stages
        $error("pipeline_elastic: NOF_STAGES must be >= 1");
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("pipeline_elastic: WIDTH must be >= 1");
    end

    for (genvar k = 0; k < NOF_STAGES; k++) begin : g_stage

        stage_state_e     state_q;
        stage_state_e     state_d;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] main_d;
        logic [WIDTH-1:0] skid_q;
        logic [WIDTH-1:0] skid_d;
        logic             in_ready_q;
        logic             in_ready_d;

        logic             in_valid_s;
        logic [WIDTH-1:0] in_data_s;
        logic             out_ready_s;
        logic             in_xfer_s;
        logic             out_xfer_s;

        // Upstream side: the block input for stage 0, else the previous stage.
        if (k == 0) begin : g_in_first
            assign in_valid_s = s_valid_i;
            assign in_data_s  = s_data_i;
        end else begin : g_in_chain
            assign in_valid_s = stage_valid[k-1];
            assign in_data_s  = stage_data[k-1];
        end

        // Downstream side: the consumer for the last stage, else the next
        // stage's registered ready.
        if (k == NOF_STAGES - 1) begin : g_out_last
            assign out_ready_s = m_ready_i;
        end else begin : g_out_chain
            assign out_ready_s = stage_ready[k+1];
        end

        assign in_xfer_s  = in_valid_s & in_ready_q;
        assign out_xfer_s = state_q[0] & out_ready_s;

        // State, data and ready registers; asynchronous clear discards all words.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q    <= ST_EMPTY;
                main_q     <= {WIDTH{1'b0}};
                skid_q     <= {WIDTH{1'b0}};
                in_ready_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                main_q     <= main_d;
                skid_q     <= skid_d;
                in_ready_q <= in_ready_d;
            end
        end

        // Next-state logic: occupancy changes by +1 on input-only, -1 on
        // output-only, and stays put when both sides transfer.
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_d = ST_HALF;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_HALF: begin
                    if (in_xfer_s && !out_xfer_s) begin
                        state_d = ST_FULL;
                    end else if (!in_xfer_s && out_xfer_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_HALF;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        state_d = ST_HALF;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding 2'b10: recover to a clean empty stage.
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // Output/datapath logic: main always holds the oldest word; the skid
        // register only catches the word that arrives while main is stalled.
        // A drained main register keeps its last value rather than clearing.
        always_comb begin
            main_d = main_q;
            skid_d = skid_q;
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        main_d = in_data_s;
                    end else begin
                        main_d = main_q;
                    end
                end
                ST_HALF: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_d = in_data_s;
                    end else if (in_xfer_s) begin
                        skid_d = in_data_s;
                    end else begin
                        main_d = main_q;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        main_d = skid_q;
                    end else begin
                        main_d = main_q;
                    end
                end
                default: begin
                    main_d = main_q;
                    skid_d = skid_q;
                end
            endcase
            // Ready is the registered complement of the next skid-valid flag,
            // so it never sees same-cycle out_ready combinationally.
            in_ready_d = (state_d != ST_FULL);
        end

        assign stage_valid[k] = state_q[0];
        assign stage_data[k]  = main_q;
        assign stage_ready[k] = in_ready_q;
    end

    assign s_ready_o = stage_ready[0];
    assign m_valid_o = stage_valid[NOF_STAGES-1];
    assign m_data_o  = stage_data[NOF_STAGES-1];

endmodule

// File: tb/tb_pipeline_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipeline_elastic
//
// Self-checking bench for pipeline_elastic. Instance "a" is WIDTH=8,
// NOF_STAGES=3; instance "b" is WIDTH=1, NOF_STAGES=1. Words are pushed into
// an expected-queue when accepted at the input and popped/compared by a
// separate output monitor when they leave.
// -----------------------------------------------------------------------------
module tb_pipeline_elastic;

    logic       clk;
    logic       rst;

    logic       s_valid_a;
    logic [7:0] s_data_a;
    logic       s_ready_a;
    logic       m_valid_a;
    logic [7:0] m_data_a;
    logic       m_ready_a;

    logic       s_valid_b;
    logic [0:0] s_data_b;
    logic       s_ready_b;
    logic       m_valid_b;
    logic [0:0] m_data_b;
    logic       m_ready_b;

    int         checks   = 0;
    int         failures = 0;

    logic [7:0] a_q[$];
    logic [0:0] b_q[$];
    bit         b_phase = 1'b0;

    logic       a_prev_stall = 1'b0;
    logic [7:0] a_prev_data  = 8'h00;

    pipeline_elastic #(.WIDTH(8), .NOF_STAGES(3)) u_dut_a (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid_a),
        .s_data_i  (s_data_a),
        .s_ready_o (s_ready_a),
        .m_valid_o (m_valid_a),
        .m_data_o  (m_data_a),
        .m_ready_i (m_ready_a)
    );

    pipeline_elastic #(.WIDTH(1), .NOF_STAGES(1)) u_dut_b (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid_b),
        .s_data_i  (s_data_b),
        .s_ready_o (s_ready_b),
        .m_valid_o (m_valid_b),
        .m_data_o  (m_data_b),
        .m_ready_i (m_ready_b)
    );

    // 10-unit clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input-side scoreboard feed: a word accepted on the coming edge is expected out later.
    always @(negedge clk) begin
        if (rst) begin
            a_q.delete();
            b_q.delete();
        end else begin
            if (s_valid_a && s_ready_a) a_q.push_back(s_data_a);
            if (s_valid_b && s_ready_b) b_q.push_back(s_data_b);
        end
    end

    // Output monitor for instance a: order, no spurious words, stall stability.
    always @(negedge clk) begin
        if (rst) begin
            a_prev_stall = 1'b0;
        end else begin
            if (a_prev_stall) begin
                chk("a_stall_valid", m_valid_a, 1'b1);
                chk("a_stall_data", m_data_a, a_prev_data);
            end
            if (m_valid_a && a_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_word: actual=%0h required=none", m_data_a);
            end else if (m_valid_a && m_ready_a) begin
                chk("a_out_data", m_data_a, a_q.pop_front());
            end
            a_prev_stall = m_valid_a && !m_ready_a;
            a_prev_data  = m_data_a;
        end
    end

    // Output monitor for instance b.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid_b && b_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_word: actual=%0h required=none", m_data_b);
            end else if (m_valid_b && m_ready_b) begin
                chk("b_out_data", m_data_b, b_q.pop_front());
            end
        end
    end

    // Occupancy bound for instance b, sampled once per cycle after the edge.
    always @(posedge clk) begin
        #2;
        if (b_phase && !rst) chk("b_occupancy_le2", (b_q.size() <= 2), 1'b1);
    end

    task automatic drain_a(input string name);
        int n = 0;
        s_valid_a = 1'b0;
        m_ready_a = 1'b1;
        while ((a_q.size() != 0 || m_valid_a) && n < 30) begin
            tick();
            n++;
        end
        chk(name, a_q.size(), 0);
    endtask

    // Watchdog: a hang is reported as a failure.
    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         acc;
        int         sent;
        int         cyc;
        logic       r0;
        logic [7:0] lfsr;

        rst       = 1'b1;
        s_valid_a = 1'b0;
        s_data_a  = 8'h00;
        m_ready_a = 1'b0;
        s_valid_b = 1'b0;
        s_data_b  = 1'b0;
        m_ready_b = 1'b0;

        // Reset state and first ready after release.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_mvalid", m_valid_a, 1'b0);
        chk("rst_a_mdata", m_data_a, 8'h00);
        chk("rst_a_sready", s_ready_a, 1'b0);
        chk("rst_b_sready", s_ready_b, 1'b0);
        chk("rst_b_mvalid", m_valid_b, 1'b0);
        rst = 1'b0;
        #1;
        chk("rel_a_sready_before_edge", s_ready_a, 1'b0);
        tick();
        chk("rel_a_sready_after_edge", s_ready_a, 1'b1);
        chk("rel_b_sready_after_edge", s_ready_b, 1'b1);

        // Streaming 0x01..0x10 with the consumer always ready.
        m_ready_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_valid_a = 1'b1;
            s_data_a  = 8'(i + 1);
            chk("a_stream_sready", s_ready_a, 1'b1);
            tick();
            if (i >= 2) begin
                chk("a_stream_valid", m_valid_a, 1'b1);
                chk("a_stream_data", m_data_a, 8'(i - 1));
            end else begin
                chk("a_stream_latency", m_valid_a, 1'b0);
            end
        end
        s_valid_a = 1'b0;
        repeat (4) tick();
        chk("a_empty_valid", m_valid_a, 1'b0);
        chk("a_empty_data_held", m_data_a, 8'h10);
        chk("a_stream_drained", a_q.size(), 0);

        // Full backpressure: exactly 2*3 words fit.
        m_ready_a = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            s_valid_a = 1'b1;
            s_data_a  = 8'(8'hA0 + acc);
            if (s_ready_a) acc++;
            tick();
        end
        chk("a_full_count", acc, 6);
        chk("a_full_sready", s_ready_a, 1'b0);
        chk("a_full_mvalid", m_valid_a, 1'b1);
        chk("a_full_mdata", m_data_a, 8'hA0);
        drain_a("a_full_drained");
        chk("a_full_sready_back", s_ready_a, 1'b1);

        // Random valid/ready traffic; ready must not follow same-cycle m_ready.
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            r0        = s_ready_a;
            m_ready_a = 1'($urandom_range(0, 1));
            #1;
            chk("a_sready_indep_mready", s_ready_a, r0);
            s_valid_a = 1'($urandom_range(0, 1));
            s_data_a  = 8'($urandom_range(0, 255));
            if (s_valid_a && s_ready_a) sent++;
            tick();
            cyc++;
        end
        chk("a_rand_sent", sent, 10000);
        drain_a("a_rand_drained");

        // Reset with four words buffered: nothing stale after release.
        m_ready_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid_a = 1'b1;
            s_data_a  = 8'(8'hB0 + i);
            tick();
        end
        s_valid_a = 1'b0;
        tick();
        tick();
        chk("a_pre_rst_valid", m_valid_a, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("a_midrst_mvalid", m_valid_a, 1'b0);
        chk("a_midrst_mdata", m_data_a, 8'h00);
        chk("a_midrst_sready", s_ready_a, 1'b0);
        @(posedge clk);
        #3;
        rst       = 1'b0;
        m_ready_a = 1'b1;
        tick();
        chk("a_postrst_sready", s_ready_a, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_no_stale_word", m_valid_a, 1'b0);
        end
        s_valid_a = 1'b1;
        s_data_a  = 8'h5A;
        tick();
        s_valid_a = 1'b0;
        tick();
        tick();
        chk("a_post_rst_5a_valid", m_valid_a, 1'b1);
        chk("a_post_rst_5a_data", m_data_a, 8'h5A);
        drain_a("a_post_rst_drained");

        // Single-stage, 1-bit: continuous input, consumer toggles every cycle.
        b_phase   = 1'b1;
        m_ready_b = 1'b0;
        lfsr      = 8'h5B;
        acc       = 0;
        for (int i = 0; i < 40; i++) begin
            s_valid_b = 1'b1;
            s_data_b  = lfsr[0];
            if (s_ready_b) acc++;
            m_ready_b = ~m_ready_b;
            tick();
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        chk("b_accepted_min", (acc >= 16), 1'b1);
        s_valid_b = 1'b0;
        m_ready_b = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("b_drained", b_q.size(), 0);
        chk("b_final_mvalid", m_valid_b, 1'b0);
        b_phase = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
